// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: control inputs from the pipeline, memory read port,
// and the delivered-instruction output toward the instruction register.
//
// Handshake semantics: instr_valid is a single-cycle strobe with no ready
// back-pressure on it. When instr_valid is high, instr and instr_pc describe
// one delivered instruction, and the consumer must take it in that cycle.
// Back-pressure is applied ahead of delivery through stall. While stall is
// high, the fetched word is held internally and is not presented.
interface fetch_if #(
    parameter int ADDR_W = 10
);
    logic              stall;
    logic              redirect;
    logic              redirect_abs;
    logic [15:0]       redirect_off;
    logic [15:0]       mem_data;
    logic [ADDR_W-1:0] addra;
    logic [15:0]       instr;
    logic              instr_valid;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        input  stall, redirect, redirect_abs, redirect_off, mem_data,
        output addra, instr, instr_valid, instr_pc
    );

    modport slave (
        output stall, redirect, redirect_abs, redirect_off, mem_data,
        input  addra, instr, instr_valid, instr_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage.
// The unit keeps the PC and drives the synchronous block memory from it. Each
// instruction takes two cycles: an issue cycle and a capture cycle.
// A downstream stall parks the captured word in a hold register.
// A redirect loads a new PC and drops any word that is in flight.
module fetch_unit #(
    parameter int ADDR_W   = 10,
    parameter int RESET_PC = 0
) (
    input  logic        CLK,
    input  logic        reset,
    fetch_if.master     bus,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_ISSUE   = 2'd0,
        S_CAPTURE = 2'd1,
        S_STALL   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       hold_q, hold_d;
    logic [15:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_inc;
    logic              unused_off_bits;

    // A relative target is taken from the last delivered instruction, not
    // from the current fetch PC. The result wraps modulo 2^ADDR_W.
    always_comb begin
        target = bus.redirect_abs ? bus.redirect_off[ADDR_W-1:0]
                                  : instr_pc_q + bus.redirect_off[ADDR_W-1:0];
        pc_inc = pc_q + ADDR_W'(1);
    end

    assign unused_off_bits = &{1'b0, bus.redirect_off[15:ADDR_W]};

    // Next-state and datapath decode. Redirect has priority over stall.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_d     = hold_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = 1'b0;
        case (state_q)
            S_ISSUE: begin
                // Stall is ignored here because the address is issued regardless.
                if (bus.redirect) begin
                    pc_d = target;
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (bus.redirect) begin
                    pc_d    = target;
                    state_d = S_ISSUE;
                end else if (bus.stall) begin
                    hold_d  = bus.mem_data;
                    state_d = S_STALL;
                end else begin
                    instr_d    = bus.mem_data;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    pc_d       = pc_inc;
                    state_d    = S_ISSUE;
                end
            end
            S_STALL: begin
                if (bus.redirect) begin
                    pc_d    = target;
                    state_d = S_ISSUE;
                end else if (!bus.stall) begin
                    instr_d    = hold_q;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    pc_d       = pc_inc;
                    state_d    = S_ISSUE;
                end
            end
            default: begin
                state_d = S_ISSUE;
            end
        endcase
    end

    // State and datapath registers. Reset (active-low) overrides everything.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q    <= S_ISSUE;
            pc_q       <= ADDR_W'(RESET_PC);
            hold_q     <= 16'h0000;
            instr_q    <= 16'h0000;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            hold_q     <= hold_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.addra       = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr_pc    = instr_pc_q;
    assign state_dbg       = state_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage feeding the 1K x 16 block memory and the instruction register path.
- Holds the program counter and drives the memory read address.
- Captures the instruction word one cycle after the address is issued and hands it downstream with a valid pulse and its PC.
- Supports downstream stall and branch/jump redirect. The memory has one-cycle synchronous read latency, so fetch throughput is one instruction per two cycles (multicycle datapath).

Parameters:
- ADDR_W, 10, word-address width of instruction memory
- RESET_PC, 0, PC value loaded on reset

Ports:
- CLK  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low reset (asserted when 0)
- stall  in  1  downstream not ready; instruction is held, not delivered
- redirect  in  1  load new PC this cycle (branch taken / jump)
- redirect_abs  in  1  1 = absolute target, 0 = PC-relative
- redirect_off  in  16  signed offset (relative) or target in [ADDR_W-1:0] (absolute)
- mem_data  in  16  block memory read data (douta)
- addra  out  ADDR_W  memory read address, equals the pc register
- instr  out  16  delivered instruction word
- instr_valid  out  1  one-cycle pulse, instr/instr_pc valid; used as IR write enable
- instr_pc  out  ADDR_W  address instr was fetched from

Behaviour:
- Reset (reset==0 at a clock edge) sets pc=RESET_PC, state=S_ISSUE, instr=0, instr_valid=0, instr_pc=0, hold register=0. Reset overrides all inputs, including mid-stall or mid-capture.
- addra = pc at all times (combinational from the register). The memory samples it at the edge ending S_ISSUE.
- S_ISSUE:
  - If redirect: pc<=target, stay S_ISSUE.
  - Else: next state S_CAPTURE.
- S_CAPTURE (mem_data is valid this cycle):
  - If redirect: discard the data, pc<=target, go to S_ISSUE, instr_valid stays 0.
  - Else if stall: hold<=mem_data, go to S_STALL.
  - Else: instr<=mem_data, instr_pc<=pc, instr_valid<=1 (next cycle), pc<=pc+1, go to S_ISSUE.
- S_STALL:
  - If redirect: discard hold, pc<=target, go to S_ISSUE.
  - Else if stall: remain.
  - Else: instr<=hold, instr_pc<=pc, instr_valid<=1, pc<=pc+1, go to S_ISSUE.
- Priority is reset > redirect > stall.
- Latency: the instruction at address A appears on instr with instr_valid high 2 cycles after A is placed on addra, absent stall or redirect.
- Target arithmetic:
  - Relative: target = instr_pc + redirect_off[ADDR_W-1:0], modulo 2^ADDR_W. The offset is relative to the last delivered instruction.
  - Absolute: target = redirect_off[ADDR_W-1:0].
- pc increment wraps: 1023+1 -> 0.
- instr and instr_pc hold their last delivered value between pulses. instr_valid is never high for two consecutive cycles.
- stall in S_ISSUE is ignored; the address is issued regardless.

Test Plan:
- Release reset with memory[0..2]=16'h1234,16'h5678,16'h9ABC, no stall -> instr_valid pulses on cycles 2, 4, 6 after release with instr=1234/5678/9ABC and instr_pc=0/1/2.
- stall=1 held 3 cycles during S_CAPTURE of address 1 (data 5678) -> no pulse while stalled; on the release cycle pc stays 1. One cycle later instr=5678, instr_pc=1, valid pulses once, addra=2.
- redirect=1, redirect_abs=1, redirect_off=16'h0200 during S_CAPTURE of address 3 -> word at 3 never delivered; addra=0x200 next cycle; next instr_pc=0x200.
- After delivering instr_pc=5, apply relative redirect_off=16'hFFFD (-3) -> next fetch address 2. Repeat from instr_pc=1 with off=-3 -> address 1022 (wrap).
- Run sequentially from pc=1022 -> instr_pc sequence 1022, 1023, 0.
- Drive reset=0 while in S_STALL with hold valid -> next cycle instr_valid=0, addra=RESET_PC. The held word is never delivered.
